pipelined_addsub: RTL and testbench
===================================

# pipelined_addsub

Parametrised, pipelined add/subtract unit that generalises the 4-bit ripple-carry adder to WIDTH bits. The carry chain is split into STAGES equal slices with one register stage per slice, so long adders close timing. Adds subtract mode, signed-overflow, zero and carry flags, and a valid/ready handshake on both sides. It sits between the register-file read ports and the ALU result mux.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; slice width is SW = WIDTH/STAGES; legal range 1..WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_ci  input  1  carry-in (add) or borrow-in (subtract).
- in_sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result.
- out_co  output  1  carry-out of the final slice.
- out_ovf  output  1  two's-complement signed overflow.
- out_zero  output  1  out_sum == 0.

## Operation
- Add: {out_co, out_sum} = in_a + in_b + in_ci.
- Subtract: out_sum = in_a − in_b − in_ci, implemented as in_a + ~in_b + ~in_ci. out_co is the raw adder carry: 1 means no borrow.
- out_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the operand after the subtract inversion.
- Slice k (0 = LSB) is added in stage k, using the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Unconsumed upper slices of A and B' travel down the pipe. Completed lower result slices are delayed alongside them.
- Each stage holds a valid bit. The final stage's valid bit drives out_valid.
- Flow control is a global stall: stall = out_valid && !out_ready. When stall is high, every stage register holds.
- When stall is low, all stages advance one step. Stage 0 loads in_valid together with its data.
- in_ready = !stall. A beat is accepted when in_valid && in_ready.
- Bubbles are not squeezed out. Data registers need not hold a defined value when their valid bit is 0.
- Flags are computed in the final stage and registered with out_sum.

## Timing
- Latency: a beat accepted on edge N appears with out_valid=1 after edge N+STAGES−1, i.e. STAGES cycles from acceptance to output.
- Throughput: one beat per cycle while out_ready stays high.
- STAGES=1: a single registered WIDTH-bit adder with 1-cycle latency.
- Reset (rst_n low, asynchronous):
  - all valid bits clear;
  - out_valid=0, out_sum=0, out_co=0, out_ovf=0, out_zero=0.
- in_ready=1 during and immediately after reset.
- Reset asserted mid-operation discards every in-flight beat. No partial result is ever presented.
- out_sum and the flags are stable while out_valid && !out_ready.
- in_valid with in_ready low: the beat is not taken. The source must hold it.
- Wrap-around: results are modulo 2^WIDTH. Carry beyond the MSB appears only on out_co.

## Test plan
- Reset and simple add: assert rst_n low, check all outputs are 0 and in_ready=1. Release reset, then drive a=10, b=2, ci=0, add. Expect out_sum=12, co=0, ovf=0, zero=0 exactly 4 cycles after acceptance (WIDTH=32, STAGES=4).
- Cross-slice carry: a=0x00FFFFFF, b=1, ci=0. Expect out_sum=0x01000000, co=0. Then a=0xFFFFFFFF, b=0, ci=1. Expect out_sum=0, co=1, zero=1.
- Subtract and overflow:
  - 5−7, ci=0 → out_sum=0xFFFFFFFE, co=0.
  - 7−5, ci=1 → out_sum=1, co=1.
  - 0x7FFFFFFF+1 add → ovf=1.
  - 0x80000000−1 → ovf=1.
- Backpressure: stream 8 back-to-back beats (a=i, b=i) with out_ready toggling on a 1-on/2-off pattern. Expect results 0,2,…,14 in order with no loss or duplication, in_ready low exactly on stall cycles, and out_sum held while stalled.
- Reset mid-stream: with 3 beats in flight, pulse rst_n low between clock edges. Expect out_valid to drop immediately and stay 0 for STAGES cycles after release; the next accepted beat returns the correct sum.
- Parameter sweep: repeat 1000 random beats with random in_ready/out_ready for (WIDTH, STAGES) = (4,1), (4,4), (32,4) and (64,8), comparing against a reference add/sub model.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipelined_addsub_if                                       |
// | Purpose  : Operand/result bus for pipelined_addsub. Carries the      |
// |            operand beat with its valid/ready handshake and the       |
// |            result beat with its flags and valid/ready handshake.     |
// | Ports    : master - drives operands and out_ready, observes results  |
// |            slave  - the arithmetic unit itself                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ci;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_co, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_co, out_ovf, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipelined_addsub                                          |
// | Purpose  : WIDTH-bit add/subtract unit with the carry chain cut into |
// |            STAGES equal slices, one register stage per slice.        |
// |            Produces carry-out, signed-overflow and zero flags.       |
// | Ports    : clk   - rising-edge clock                                 |
// |            rst_n - asynchronous active-low reset                     |
// |            bus   - operand/result handshake bus (slave side)         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave bus
);

  localparam int SW = WIDTH / STAGES;

  // Per-stage pipeline registers. Stage k holds the operands (with B
  // already inverted for subtract), the partially built result whose
  // slices 0..k are final, and the carry out of slice k.
  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q,   a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q,   b_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [STAGES-1:0]            co_q;
  logic [STAGES-1:0]            cin_w;
  logic [STAGES-1:0][SW:0]      slice_w;
  logic                         ovf_q, ovf_d;
  logic                         zero_q, zero_d;

  logic             stall_w;
  logic [WIDTH-1:0] b_eff_w;
  logic             ci_eff_w;
  logic             unused_w;

  assign stall_w  = valid_q[STAGES-1] && !bus.out_ready;
  // Subtract is A + ~B + ~borrow_in, so a borrow-in of 0 becomes carry 1.
  assign b_eff_w  = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign ci_eff_w = bus.in_ci ^ bus.in_sub;

  always_comb begin
    a_d   = '0;
    b_d   = '0;
    sum_d = '0;
    cin_w = '0;
    slice_w = '0;
    ovf_d = 1'b0;
    zero_d = 1'b0;

    a_d[0]   = bus.in_a;
    b_d[0]   = b_eff_w;
    cin_w[0] = ci_eff_w;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      sum_d[k] = sum_q[k-1];
      cin_w[k] = co_q[k-1];
    end

    // Each stage adds only its own slice; lower slices pass through.
    for (int k = 0; k < STAGES; k++) begin
      slice_w[k] = {1'b0, a_d[k][k*SW +: SW]}
                 + {1'b0, b_d[k][k*SW +: SW]}
                 + {{SW{1'b0}}, cin_w[k]};
      sum_d[k][k*SW +: SW] = slice_w[k][SW-1:0];
    end

    // Flags only need the last stage's view of the operands and result.
    ovf_d  = (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1]) &&
             (sum_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
    zero_d = (sum_d[STAGES-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (!stall_w) begin
      valid_q[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      for (int k = 0; k < STAGES; k++) begin
        co_q[k] <= slice_w[k][SW];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  // The last stage's operand copies have no consumer; they are trimmed.
  assign unused_w = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign bus.in_ready  = !stall_w;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_sum   = sum_q[STAGES-1];
  assign bus.out_co    = co_q[STAGES-1];
  assign bus.out_ovf   = ovf_q;
  assign bus.out_zero  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pipelined_addsub                                       |
// | Purpose  : Directed bench for pipelined_addsub (WIDTH=32, STAGES=4). |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pipelined_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pipelined_addsub_if #(.WIDTH(WIDTH)) ifc ();

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic sub);
    logic [31:0] bb;
    logic        cc;
    logic [32:0] r;
    logic        ovf;
    bb  = sub ? ~b : b;
    cc  = sub ? ~ci : ci;
    r   = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
    ovf = (a[31] == bb[31]) && (r[31] != a[31]);
    return {r[32], ovf, (r[31:0] == 32'd0), r[31:0]};
  endfunction

  // One beat through an empty pipe with out_ready high; checks exact latency.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sub, input logic [31:0] es,
                         input logic eco, input logic eovf, input logic ez);
    @(negedge clk);
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_a      = a;
    ifc.in_b      = b;
    ifc.in_ci     = ci;
    ifc.in_sub    = sub;
    #1;
    chk({tag, "_inrdy"}, ifc.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, ifc.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, ifc.out_valid, 1);
    chk({tag, "_sum"},   ifc.out_sum, es);
    chk({tag, "_co"},    ifc.out_co, eco);
    chk({tag, "_ovf"},   ifc.out_ovf, eovf);
    chk({tag, "_zero"},  ifc.out_zero, ez);
  endtask

  initial begin
    int          sent;
    int          got;
    int          cyc;
    logic        acc;
    logic        prev_stall;
    logic        cur_stall;
    logic [31:0] prev_sum;
    logic [34:0] expq[$];
    logic [34:0] e;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.in_ci     = 1'b0;
    ifc.in_sub    = 1'b0;
    ifc.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_sum",   ifc.out_sum, 0);
    chk("rst_co",    ifc.out_co, 0);
    chk("rst_ovf",   ifc.out_ovf, 0);
    chk("rst_zero",  ifc.out_zero, 0);
    chk("rst_inrdy", ifc.in_ready, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_inrdy", ifc.in_ready, 1);

    // Directed add/subtract vectors
    run_one("add10_2",  32'd10,         32'd2,          1'b0, 1'b0, 32'd12,         1'b0, 1'b0, 1'b0);
    run_one("xslice",   32'h00FF_FFFF,  32'd1,          1'b0, 1'b0, 32'h0100_0000,  1'b0, 1'b0, 1'b0);
    run_one("wrap",     32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 32'd0,          1'b1, 1'b0, 1'b1);
    run_one("sub5_7",   32'd5,          32'd7,          1'b0, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0);
    run_one("sub7_5b",  32'd7,          32'd5,          1'b1, 1'b1, 32'd1,          1'b1, 1'b0, 1'b0);
    run_one("ovf_add",  32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0);
    run_one("ovf_sub",  32'h8000_0000,  32'd1,          1'b0, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0);
    run_one("sub0_0",   32'd0,          32'd0,          1'b0, 1'b1, 32'd0,          1'b1, 1'b0, 1'b1);
    run_one("allones",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0);

    // Backpressure: 8 beats a=i,b=i, out_ready 1-on/2-off
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    prev_sum = '0;
    for (cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      ifc.out_ready = (cyc % 3 == 0);
      ifc.in_valid  = (sent < 8);
      ifc.in_a      = sent;
      ifc.in_b      = sent;
      ifc.in_ci     = 1'b0;
      ifc.in_sub    = 1'b0;
      #1;
      cur_stall = ifc.out_valid && !ifc.out_ready;
      chk("bp_inrdy", ifc.in_ready, !cur_stall);
      if (prev_stall) chk("bp_hold", ifc.out_sum, prev_sum);
      if (ifc.out_valid && ifc.out_ready) begin
        chk("bp_data", ifc.out_sum, 2 * got);
        got++;
      end
      acc = ifc.in_valid && ifc.in_ready;
      prev_stall = cur_stall;
      prev_sum = ifc.out_sum;
      @(posedge clk);
      if (acc) sent++;
    end
    chk("bp_count", got, 8);
    @(negedge clk);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (STAGES + 1) @(posedge clk);
    @(negedge clk);
    chk("bp_nodup", ifc.out_valid, 0);

    // Reset mid-stream: beat 0 at the output, three more in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_a = 32'd1000 + i;
      ifc.in_b = 32'd1;
      @(posedge clk);
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("mr_pre_valid", ifc.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", ifc.out_valid, 0);
    chk("mr_sum",   ifc.out_sum, 0);
    chk("mr_inrdy", ifc.in_ready, 1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      @(negedge clk);
      chk("mr_quiet", ifc.out_valid, 0);
    end
    run_one("mr_after", 32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 1'b0, 1'b0, 1'b0);

    // Random handshake traffic against the reference model
    @(negedge clk);
    ifc.in_valid = 1'b0;
    sent = 0;
    got = 0;
    for (cyc = 0; cyc < 2000 && got < 60; cyc++) begin
      @(negedge clk);
      ifc.out_ready = 1'($urandom_range(1));
      if (!ifc.in_valid && sent < 60 && $urandom_range(3) != 0) begin
        ifc.in_valid = 1'b1;
        ifc.in_a     = $urandom;
        ifc.in_b     = $urandom;
        ifc.in_ci    = 1'($urandom_range(1));
        ifc.in_sub   = 1'($urandom_range(1));
      end
      #1;
      if (ifc.out_valid && ifc.out_ready) begin
        if (expq.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("rnd_result", {ifc.out_co, ifc.out_ovf, ifc.out_zero, ifc.out_sum}, e);
        end
        got++;
      end
      acc = ifc.in_valid && ifc.in_ready;
      @(posedge clk);
      if (acc) begin
        expq.push_back(ref_model(ifc.in_a, ifc.in_b, ifc.in_ci, ifc.in_sub));
        sent++;
        #1 ifc.in_valid = 1'b0;
      end
    end
    chk("rnd_count", got, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
